addsub_seq_nbit: RTL
====================

Name: addsub_seq_nbit

Overview:
- Parametrised, digit-serial adder/subtractor for the ALU datapath.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, starting from the LSB, with a rippling carry register.
- Uses valid/ready handshakes on input and output, so multi-cycle arithmetic units can share the pipeline stall logic.
- Produces signed overflow, unsigned carry, zero and negative flags.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be >= 2.
- CHUNK, 4: bits processed per cycle. Must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK. CHUNK == WIDTH gives single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result.
- Ovfl  output  1  signed overflow.
- Cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- Zero  output  1  Sum == 0.
- Neg  output  1  Sum[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, Sum=0, Ovfl=0, Cout=0, Zero=0, Neg=0. Internal operand, carry and chunk-counter registers are cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture A, B^{WIDTH{sub}}, carry=sub, counter=0, then go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle, add chunk[counter] of A, chunk[counter] of B', and the carry. Write the CHUNK-bit result into the result register at that chunk position, update the carry, increment the counter.
  - On the cycle processing the last chunk (counter == NCHUNK-1), record the carry into the MSB and the carry out of the MSB, then go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - Sum and all flags are stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE and clear out_valid.
  - No new accept happens in the same cycle; in_ready rises on the following cycle.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles with the defaults). Minimum issue interval is NCHUNK+2 cycles.
- Flags:
  - Ovfl = carry into MSB XOR carry out of MSB.
  - Cout = raw carry out of MSB.
  - Zero and Neg are evaluated on the final Sum, after optional saturation.
- Wrap-around: without saturation, Sum is the result modulo 2^WIDTH.
- Output hold: after the output handshake, Sum and the flags keep their last values while out_valid=0, until the next result is loaded.
- Reset during BUSY or DONE: the operation is aborted and all outputs return to their reset values immediately. No partial result is ever presented.
- sub, A and B changing after acceptance have no effect on the operation in flight.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: on signed overflow, Sum saturates.
  - Positive overflow (A[MSB]==B'[MSB]==0) gives 0x7FF..F.
  - Negative overflow gives 0x800..0.
  - Ovfl is still reported as 1. Zero and Neg reflect the saturated value. Cout is unchanged, raw.
- Undefined: Sum wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. A=0x1234, B=0x0001, sub=0 -> out_valid exactly 4 cycles after accept; Sum=0x1235, Ovfl=0, Cout=0, Zero=0, Neg=0.
2. A=0x0005, B=0x0005, sub=1 -> Sum=0x0000, Zero=1, Cout=1, Ovfl=0, Neg=0.
3. A=0x7FFF, B=0x0001, sub=0 -> without macro: Sum=0x8000, Ovfl=1, Neg=1, Cout=0. With ADDSUB_SATURATE_EN: Sum=0x7FFF, Ovfl=1, Neg=0.
4. A=0x8000, B=0x0001, sub=1 -> without macro: Sum=0x7FFF, Ovfl=1, Cout=1. With macro: Sum=0x8000, Neg=1.
5. Backpressure: A=0xFFFF, B=0x0001, sub=0, hold out_ready=0 for 5 cycles while toggling in_valid and A -> out_valid, Sum=0x0000, Cout=1, Zero=1 all held stable; in_ready=0 throughout; no second operation is accepted. After out_ready=1, in_ready=1 one cycle later.
6. Reset during BUSY (counter=2) -> out_valid=0, in_ready=1, Sum=0 asynchronously. A following A=0x0010, B=0x0020 add gives Sum=0x0030 with correct latency.

Source files
------------

// File: rtl/addsub_seq_nbit_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor.
// The slave modport is the arithmetic unit; the master modport is its producer/consumer.
interface addsub_seq_nbit_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Ovfl;
   logic             Cout;
   logic             Zero;
   logic             Neg;

   modport master (
      output in_valid, A, B, sub, out_ready,
      input  in_ready, out_valid, Sum, Ovfl, Cout, Zero, Neg
   );

   modport slave (
      input  in_valid, A, B, sub, out_ready,
      output in_ready, out_valid, Sum, Ovfl, Cout, Zero, Neg
   );
endinterface

// File: rtl/addsub_seq_nbit.sv
// Digit-serial WIDTH-bit adder/subtractor, CHUNK bits per cycle from the LSB, valid/ready on both sides.
// Define ADDSUB_SATURATE_EN to clamp the result to the signed range on overflow.
module addsub_seq_nbit #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic              clk,
   input logic              rst_n,
   addsub_seq_nbit_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("addsub_seq_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             ovfl_q, cout_q, zero_q, neg_q;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] res_next, res_final;
   logic             carry_into_msb, ovfl_next;
   int               base;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      base      = int'(cnt_q) * CHUNK;
      a_chunk   = a_q[base +: CHUNK];
      b_chunk   = b_q[base +: CHUNK];
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      res_next  = res_q;
      res_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
      // Only meaningful on the last chunk: sum bit = a ^ b ^ cin recovers the carry into the MSB.
      carry_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
      ovfl_next      = carry_into_msb ^ chunk_sum[CHUNK];
`ifdef ADDSUB_SATURATE_EN
      // On overflow both operand MSBs agree, so A's MSB gives the direction of overflow.
      if (ovfl_next) begin
         res_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res_final = res_next;
      end
`else
      res_final = res_next;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here is reset, including operand and working registers, so an aborted
      // operation leaves nothing behind.
      if (!rst_n) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         ovfl_q  <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B ^ {WIDTH{bus.sub}};
                  carry_q <= bus.sub;
                  cnt_q   <= '0;
                  state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               res_q   <= res_next;
               carry_q <= chunk_sum[CHUNK];
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  sum_q  <= res_final;
                  ovfl_q <= ovfl_next;
                  cout_q <= chunk_sum[CHUNK];
                  zero_q <= (res_final == '0);
                  neg_q  <= res_final[WIDTH-1];
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.Sum       = sum_q;
   assign bus.Ovfl      = ovfl_q;
   assign bus.Cout      = cout_q;
   assign bus.Zero      = zero_q;
   assign bus.Neg       = neg_q;
endmodule
